// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned ITER_COUNT     = 32;
    localparam int unsigned COUNT_W        = 6;

    typedef enum logic [1:0] {
        StIdle,
        StMult,
        StDiv,
        StDone
    } state_e;

    // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
    function automatic logic [DEFAULT_DATA_W-1:0] abs_val(input logic [DEFAULT_DATA_W-1:0] v);
        return v[DEFAULT_DATA_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter: clears to 0, counts up while enabled, stops at ITER_COUNT.
module multdiv_counter
    import multdiv_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic done_o
);

    logic [COUNT_W-1:0] count_q, count_d;

    assign done_o = (count_q == COUNT_W'(ITER_COUNT));

    // Next count: clear wins, saturate at the terminal value.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && !done_o) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) and divide (restoring), 33-cycle latency.
// Optional divider datapath and DIV state enabled by defining MULTDIV_DIV_EN; without it
// a divide request completes immediately with result 0 and exception 1.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ctrl_mult,
    input  logic              ctrl_div,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    output logic [DATA_W-1:0] result,
    output logic              exception,
    output logic              result_rdy,
    output logic              busy
);

    localparam int unsigned AccW = 2 * DATA_W + 1;

    state_e            state_q, state_d;
    // Multiply: Booth product {hi, lo, q-1}. Divide: {remainder(33), quotient/dividend(32)}.
    logic [AccW-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              exc_q, exc_d;
    logic              rdy_q, rdy_d;
    logic              cnt_clear, cnt_en, cnt_done;
    logic [DATA_W:0]   booth_sum;
    logic [AccW-1:0]   booth_next;
    logic              mult_ovf;
`ifdef MULTDIV_DIV_EN
    logic              neg_q, neg_d;
    logic [DATA_W:0]   rem_shift, rem_diff;
    logic [AccW-1:0]   div_next;
    logic [DATA_W-1:0] quo_mag;
`endif

    multdiv_counter u_counter (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .clear_i (cnt_clear),
        .en_i    (cnt_en),
        .done_o  (cnt_done)
    );

    // Booth step: add/subtract multiplicand into a 33-bit upper half, then arithmetic shift.
    always_comb begin
        booth_sum = {acc_q[AccW-1], acc_q[AccW-1:DATA_W+1]};
        case (acc_q[1:0])
            2'b01:   booth_sum = {acc_q[AccW-1], acc_q[AccW-1:DATA_W+1]} + {opb_q[DATA_W-1], opb_q};
            2'b10:   booth_sum = {acc_q[AccW-1], acc_q[AccW-1:DATA_W+1]} - {opb_q[DATA_W-1], opb_q};
            default: ;
        endcase
        booth_next = {booth_sum, acc_q[DATA_W:1]};
        // Product bits [63:31] must all agree for the low word to be exact.
        mult_ovf   = ~((&acc_q[AccW-1:DATA_W]) | ~(|acc_q[AccW-1:DATA_W]));
    end

`ifdef MULTDIV_DIV_EN
    // Restoring divide step on magnitudes; bit DATA_W of the difference is the borrow.
    always_comb begin
        rem_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
        rem_diff  = rem_shift - {1'b0, opb_q};
        if (!rem_diff[DATA_W]) begin
            div_next = {rem_diff, acc_q[DATA_W-2:0], 1'b1};
        end else begin
            div_next = {rem_shift, acc_q[DATA_W-2:0], 1'b0};
        end
        quo_mag = acc_q[DATA_W-1:0];
    end
`endif

    // FSM next state and datapath updates.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        result_d  = result_q;
        exc_d     = exc_q;
        rdy_d     = 1'b0;
        cnt_en    = 1'b0;
        cnt_clear = (state_q == StIdle);
`ifdef MULTDIV_DIV_EN
        neg_d     = neg_q;
`endif
        case (state_q)
            StIdle: begin
                if (ctrl_mult) begin
                    state_d  = StMult;
                    acc_d    = {{DATA_W{1'b0}}, data_b, 1'b0};
                    opb_d    = data_a;
                    result_d = '0;
                    exc_d    = 1'b0;
                end else if (ctrl_div) begin
`ifdef MULTDIV_DIV_EN
                    state_d  = StDiv;
                    acc_d    = {{(DATA_W + 1){1'b0}}, abs_val(data_a)};
                    opb_d    = abs_val(data_b);
                    neg_d    = data_a[DATA_W-1] ^ data_b[DATA_W-1];
                    result_d = '0;
                    exc_d    = 1'b0;
`else
                    state_d  = StDone;
                    result_d = '0;
                    exc_d    = 1'b1;
                    rdy_d    = 1'b1;
`endif
                end
            end
            StMult: begin
                if (cnt_done) begin
                    state_d  = StDone;
                    result_d = acc_q[DATA_W:1];
                    exc_d    = mult_ovf;
                    rdy_d    = 1'b1;
                end else begin
                    acc_d  = booth_next;
                    cnt_en = 1'b1;
                end
            end
`ifdef MULTDIV_DIV_EN
            StDiv: begin
                if (cnt_done) begin
                    state_d = StDone;
                    rdy_d   = 1'b1;
                    if (opb_q == '0) begin
                        result_d = '0;
                        exc_d    = 1'b1;
                    end else begin
                        result_d = neg_q ? (~quo_mag + 1'b1) : quo_mag;
                        // Only 0x80000000 / -1 yields a positive quotient with the MSB set.
                        exc_d    = ~neg_q & quo_mag[DATA_W-1];
                    end
                end else begin
                    acc_d  = div_next;
                    cnt_en = 1'b1;
                end
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
`ifdef MULTDIV_DIV_EN
            neg_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
`ifdef MULTDIV_DIV_EN
            neg_q    <= neg_d;
`endif
        end
    end

    assign result     = result_q;
    assign exception  = exc_q;
    assign result_rdy = rdy_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit; divide vectors follow the MULTDIV_DIV_EN build option.
module tb_multdiv_unit;

    logic        clock      = 1'b0;
    logic        reset_n    = 1'b0;
    logic        ctrl_mult  = 1'b0;
    logic        ctrl_div   = 1'b0;
    logic [31:0] data_a     = '0;
    logic [31:0] data_b     = '0;
    logic [31:0] result;
    logic        exception;
    logic        result_rdy;
    logic        busy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clock = ~clock;

    multdiv_unit #(
        .DATA_W (32)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .ctrl_mult  (ctrl_mult),
        .ctrl_div   (ctrl_div),
        .data_a     (data_a),
        .data_b     (data_b),
        .result     (result),
        .exception  (exception),
        .result_rdy (result_rdy),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called 1 time unit after an edge; returns 1 time unit after the accepting edge.
    task automatic start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        ctrl_mult = m;
        ctrl_div  = d;
        data_a    = a;
        data_b    = b;
        @(posedge clock);
        #1;
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
        data_a    = 32'hDEAD_BEEF;
        data_b    = 32'h1234_5678;
    endtask

    // Edges from now until result_rdy is seen, bounded.
    task automatic wait_rdy(output int lat);
        lat = 0;
        while (!result_rdy && lat < 60) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_exc, input int exp_lat);
        int lat;
        start(m, d, a, b);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_rdy(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, result, exp_res);
        check({tag, "_exc"}, 32'(exception), 32'(exp_exc));
        @(posedge clock);
        #1;
        check({tag, "_rdy_off"}, 32'(result_rdy), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        int pulses;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_res", result, 32'd0);
        check("rst_exc", 32'(exception), 32'd0);
        check("rst_rdy", 32'(result_rdy), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Multiply vectors
        run_op("mul_6x-7", 1'b1, 1'b0, 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFD6, 1'b0, 33);
        run_op("mul_ovf", 1'b1, 1'b0, 32'h4000_0000, 32'd4, 32'h0000_0000, 1'b1, 33);
        run_op("mul_m1xm1", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 33);
        run_op("mul_minsq", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b1, 33);

        // Both starts high: multiply wins; a divide pulse while busy is ignored
        start(1'b1, 1'b1, 32'd3, 32'd5);
        repeat (9) begin
            @(posedge clock);
            #1;
        end
        ctrl_div = 1'b1;
        data_a   = 32'd100;
        data_b   = 32'd10;
        @(posedge clock);
        #1;
        ctrl_div = 1'b0;
        wait_rdy(lat);
        check("prio_lat", 32'(lat + 10), 32'd33);
        check("prio_res", result, 32'd15);
        check("prio_exc", 32'(exception), 32'd0);
        pulses = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (result_rdy) pulses++;
        end
        check("prio_no_second_rdy", 32'(pulses), 32'd0);
        check("hold_res", result, 32'd15);

        // Reset in the middle of a multiply
        start(1'b1, 1'b0, 32'd100, 32'd3);
        repeat (14) begin
            @(posedge clock);
            #1;
        end
        check("midrst_busy_before", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_res", result, 32'd0);
        check("midrst_exc", 32'(exception), 32'd0);
        check("midrst_rdy", 32'(result_rdy), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        pulses  = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (result_rdy || busy) pulses++;
        end
        check("midrst_quiet", 32'(pulses), 32'd0);
        run_op("mul_2x3", 1'b1, 1'b0, 32'd2, 32'd3, 32'd6, 1'b0, 33);

`ifdef MULTDIV_DIV_EN
        run_op("div_-7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
        run_op("div_100/7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 1'b0, 33);
        run_op("div_by0", 1'b0, 1'b1, 32'd5, 32'd0, 32'd0, 1'b1, 33);
        run_op("div_min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33);
        run_op("div_min/1", 1'b0, 1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, 33);
`else
        // Divider absent: result_rdy in the cycle following the accepting edge
        run_op("nodiv_9/3", 1'b0, 1'b1, 32'd9, 32'd3, 32'd0, 1'b1, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
